// File: rtl/aes_host_bridge_if.sv
// Host-side byte streams of the AES host bridge: command/message bytes in, result bytes out.
// The master modport is the host transport; the slave modport is the bridge.
interface aes_host_bridge_if;
    logic [7:0] inData;
    logic       inValid;
    logic       inReady;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;

    modport master (
        output inData, inValid, outReady,
        input  inReady, outData, outValid
    );

    modport slave (
        input  inData, inValid, outReady,
        output inReady, outData, outValid
    );
endinterface

// File: rtl/aes_host_bridge.sv
// Byte-stream front end for the AES core: loads cmd + 16 message bytes, runs the core, returns 17 result bytes.
// Optional RUN watchdog with a 0xEE error byte when AES_HOST_TIMEOUT_EN is defined.
module aes_host_bridge #(
    parameter int TIMEOUT = 4096
) (
    input  logic             clock,
    input  logic             reset,
    aes_host_bridge_if.slave host,
    output logic             busy,
    output logic             coreReset,
    output logic             coreEncOrDec,
    output logic [0:2]       coreKeySize,
    output logic [0:127]     coreMessageIn,
    input  logic             coreDone,
    input  logic [0:135]     coreMessageOut
);

    if (TIMEOUT < 2) begin : g_timeout_range
        $error("aes_host_bridge: TIMEOUT must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        SEND
`ifdef AES_HOST_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    state_t       state;
    logic [4:0]   cnt;
    logic         run_first;
    logic [0:127] rest;
    logic         in_fire;
    logic         out_fire;

`ifdef AES_HOST_TIMEOUT_EN
    localparam int            TW    = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo;
`endif

    assign in_fire  = host.inValid && host.inReady;
    assign out_fire = host.outValid && host.outReady;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            run_first     <= 1'b0;
            rest          <= '0;
            host.inReady  <= 1'b1;
            host.outValid <= 1'b0;
            host.outData  <= '0;
            busy          <= 1'b0;
            coreReset     <= 1'b1;
            coreEncOrDec  <= 1'b0;
            coreKeySize   <= '0;
            coreMessageIn <= '0;
`ifdef AES_HOST_TIMEOUT_EN
            tmo           <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        coreEncOrDec <= host.inData[3];
                        coreKeySize  <= host.inData[2:0];
                        cnt          <= '0;
                        busy         <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        // byte k lands in [8k:8k+7], so byte 0 is the most significant
                        coreMessageIn[{cnt[3:0], 3'b000} +: 8] <= host.inData;
                        if (cnt == 5'd15) begin
                            host.inReady <= 1'b0;
                            coreReset    <= 1'b0;
                            run_first    <= 1'b1;
`ifdef AES_HOST_TIMEOUT_EN
                            tmo          <= '0;
`endif
                            state        <= RUN;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                RUN: begin
                    run_first <= 1'b0;
                    // the core's done is still settling out of reset in the first RUN cycle
                    if (!run_first && coreDone) begin
                        rest          <= coreMessageOut[8:135];
                        host.outData  <= coreMessageOut[0:7];
                        host.outValid <= 1'b1;
                        coreReset     <= 1'b1;
                        cnt           <= '0;
                        state         <= SEND;
                    end
`ifdef AES_HOST_TIMEOUT_EN
                    else if (tmo == TLAST) begin
                        host.outData  <= 8'hEE;
                        host.outValid <= 1'b1;
                        coreReset     <= 1'b1;
                        state         <= ERR;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
`endif
                end
                SEND: begin
                    if (out_fire) begin
                        if (cnt == 5'd16) begin
                            host.outValid <= 1'b0;
                            host.inReady  <= 1'b1;
                            busy          <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            cnt          <= cnt + 5'd1;
                            host.outData <= rest[0:7];
                            rest         <= rest << 8;
                        end
                    end
                end
`ifdef AES_HOST_TIMEOUT_EN
                ERR: begin
                    if (out_fire) begin
                        host.outValid <= 1'b0;
                        host.inReady  <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes_host_bridge.md
# aes_host_bridge

Byte-stream front end that drives the AES core from the host side. Collects a command byte plus a 16-byte message from an 8-bit valid/ready input stream and presents the message, mode and key size to the core. It then releases the core from reset, waits for `done`, and returns the core's 136-bit result as 17 bytes on an 8-bit valid/ready output stream. It sits between the board-level byte transport (UART/USB shim) and the `aes` top.

## Interface
- `TIMEOUT`, 4096: cycles allowed in RUN before abort (used only with `AES_HOST_TIMEOUT_EN`); must be ≥ 2.
- `clock` input 1: single clock domain (DE2-115 50 MHz).
- `reset` input 1: asynchronous, active-low reset.
- `inData` input 8: host byte.
- `inValid` input 1: `inData` valid.
- `inReady` output 1: bridge accepts a byte; a transfer occurs when `inValid && inReady`.
- `outData` output 8: result/status byte.
- `outValid` output 1: `outData` valid.
- `outReady` input 1: host accepts; a transfer occurs when `outValid && outReady`.
- `busy` output 1: high in any state other than IDLE.
- `coreReset` output 1: active-high hold of the AES core; high means the core is held.
- `coreEncOrDec` output 1: to core `encOrDec`.
- `coreKeySize` output [0:2]: to core `keySize`.
- `coreMessageIn` output [0:127]: to core `messageIn`.
- `coreDone` input 1: core `done`.
- `coreMessageOut` input [0:135]: core `messageOut`.

## Operation
- States: IDLE, LOAD, RUN, SEND, plus ERR only with the timeout macro defined.
- **IDLE:** `inReady`=1. Accepting the command byte latches:
  - `coreEncOrDec` ← cmd[3]
  - `coreKeySize[0:2]` ← cmd[2:0], with cmd[2] → `keySize[0]`
  - cmd[7:4] is ignored.
  - Clears the byte counter and moves to LOAD.
- **LOAD:** `inReady`=1. Byte k (k = 0..15) is written to `coreMessageIn[8k +: 8]` in the [0:127] ordering, so byte 0 lands in bits [0:7]. The counter increments per accepted byte. Accepting byte 15 moves to RUN.
- **RUN:** `inReady`=0 and `coreReset`=0.
  - `coreDone` is ignored in the first RUN cycle and sampled from the second RUN cycle on.
  - On the first sampled high, capture `coreMessageOut` into a 136-bit shift register, set `coreReset`=1, clear the counter and go to SEND.
- **SEND:** byte j (j = 0..16) is `coreMessageOut[8j +: 8]`, so byte 0 is bits [0:7].
  - `outValid` stays high with `outData` stable until `outReady`.
  - After each transfer, the next byte is presented in the following cycle; there are no idle gaps.
  - The transfer of byte 16 drops `outValid` and returns to IDLE.
- `coreEncOrDec`, `coreKeySize` and `coreMessageIn` hold their values from LOAD until the next command byte.
- Counters are 5 bits and never wrap: the LOAD limit is 15 and the SEND limit is 16.
- `inValid` is ignored outside IDLE/LOAD. `outReady` is ignored when `outValid`=0.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - state IDLE
  - `inReady`=1, `outValid`=0, `outData`=0x00, `busy`=0
  - `coreReset`=1, `coreEncOrDec`=0, `coreKeySize`=0, `coreMessageIn`=0
  - counters 0
- Reset mid-operation aborts immediately in any state. Partial message data is discarded (cleared to 0). `coreReset` returns to 1 and the host must resend starting with a command byte.
- Load takes a minimum of 17 cycles (one byte per cycle).
- `coreReset` falls in the cycle after byte 15 is accepted.
- `outValid` rises in the cycle after `coreDone` is sampled high. `coreReset` rises in that same cycle.
- Unload takes a minimum of 17 cycles with `outReady` held at 1.
- `inReady` is a registered state decode, with no combinational path from `outReady` or `inValid`.

## Configuration
- **`AES_HOST_TIMEOUT_EN` defined:**
  - A cycle counter runs in RUN. If `coreDone` has not been seen after `TIMEOUT` cycles in RUN, the bridge sets `coreReset`=1 and enters ERR.
  - ERR presents a single byte 0xEE (valid/ready as in SEND), then returns to IDLE.
  - If `coreDone` rises on the same cycle the counter expires, `done` wins and the bridge goes to SEND.
- **Not defined:** no timeout counter and no ERR state. RUN waits on `coreDone` indefinitely; only `reset` exits.

## Test plan
- **Encrypt path:** cmd 0x08 plus bytes 0x00..0x0F.
  - Expect `coreEncOrDec`=1, `coreKeySize`=3'b000 and `coreMessageIn`=0x000102…0F.
  - Expect `coreReset` to fall on the next cycle.
  - Model drives `coreDone` with `coreMessageOut`=0x10..0x20. Expect 17 output bytes 0x10..0x20 in order, then `busy`=0.
- **Key size mapping:** cmd 0x05. Expect `coreEncOrDec`=0 and `coreKeySize`=3'b101.
- **Backpressure:** `outReady` toggles randomly during SEND. Every byte must be held stable until it transfers, with no loss or duplication, and the count is exactly 17.
- **Gapped input:** `inValid` low for 3 cycles between message bytes. Assembly is unchanged, and `inReady`=0 throughout RUN and SEND.
- **Reset mid-LOAD:** `reset`=0 after 7 message bytes.
  - All outputs take their reset values at once.
  - A fresh 17-byte load then completes normally.
- **Timeout (with macro, `TIMEOUT`=16):** `coreDone` is never driven. Exactly 16 RUN cycles pass, then `coreReset`=1, one 0xEE byte is output, and the bridge is back in IDLE.
